// File: rtl/decode_stage_sb_pkg.sv
// Shared decode definitions: RV32 major opcodes, the bubble encoding,
// operand forward-select type and the opcode-driven decode helpers.
package decode_stage_sb_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_RR     = 7'b0110011;

  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  typedef enum logic [1:0] {FS_ZERO, FS_FWD, FS_WB, FS_RF} fwd_sel_e;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic b_is_rs2;
  } dec_ctl_t;

  function automatic dec_ctl_t dec_ctl(input logic [6:0] op);
    dec_ctl_t c;
    c = '0;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: c.use_rs1 = 1'b1;
      OP_RR, OP_BRANCH: begin
        c.use_rs1  = 1'b1;
        c.use_rs2  = 1'b1;
        c.b_is_rs2 = 1'b1;
      end
      OP_STORE: begin
        c.use_rs1 = 1'b1;
        c.use_rs2 = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  // 32-bit sign-extended immediate; callers widen to XLEN.
  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    logic [31:0] imm;
    case (i[6:0])
      OP_LUI, OP_AUIPC: imm = {i[31:12], 12'b0};
      OP_STORE:         imm = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_JAL:           imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      OP_BRANCH:        imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      default:          imm = {{20{i[31]}}, i[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_sb_regfile.sv
// Architectural register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero.
module decode_regfile_p #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int PTR_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [PTR_W-1:0] wa_i,
  input  logic [XLEN-1:0]  wd_i,
  input  logic [PTR_W-1:0] ra1_i,
  input  logic [PTR_W-1:0] ra2_i,
  output logic [XLEN-1:0]  rd1_o,
  output logic [XLEN-1:0]  rd2_o
);

  logic [NREGS-1:0][XLEN-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    mem_q <= '0;
    else if (we_i && wa_i != '0)   mem_q[wa_i] <= wd_i;
  end

  assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];

endmodule

// File: rtl/decode_stage_sb.sv
// Decode stage: operand forwarding, load scoreboard interlock, registered
// ID/EX boundary with valid/ready on both sides, saturating stall counter.
module decode_stage_sb
  import decode_stage_sb_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int N_FWD = 3,
  parameter  int CNT_W = 16,
  localparam int PTR_W = $clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        if_valid,
  output logic                        if_ready,
  input  logic [31:0]                 if_inst,
  input  logic [XLEN-1:0]             if_pc,
  output logic                        ex_valid,
  input  logic                        ex_ready,
  output logic [31:0]                 ex_inst,
  output logic [XLEN-1:0]             ex_pc,
  output logic [XLEN-1:0]             ex_dat_a,
  output logic [XLEN-1:0]             ex_dat_b,
  output logic [XLEN-1:0]             ex_rd2,
  input  logic                        flush,
  input  logic [N_FWD-1:0]            fwd_we,
  input  logic [N_FWD-1:0][PTR_W-1:0] fwd_dst,
  input  logic [N_FWD-1:0][XLEN-1:0]  fwd_dat,
  input  logic                        rgf_we,
  input  logic [PTR_W-1:0]            rgf_wa,
  input  logic [XLEN-1:0]             rgf_wd,
  input  logic                        ld_done,
  input  logic [PTR_W-1:0]            ld_dst,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int FIDX_W = (N_FWD > 1) ? $clog2(N_FWD) : 1;

  dec_ctl_t                     ctl;
  logic [1:0][PTR_W-1:0]        rs;
  logic [1:0]                   use_rs;
  logic [1:0][XLEN-1:0]         rf_rd, opnd;
  fwd_sel_e                     sel [2];
  logic [1:0][FIDX_W-1:0]       fidx;
  logic [XLEN-1:0]              imm_x;
  logic                         hazard, can_load, issue, ex_is_load;
  logic [PTR_W-1:0]             ex_rd;
  logic [NREGS-1:0]             sb_q, sb_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         ex_valid_q;
  logic [31:0]                  ex_inst_q;
  logic [XLEN-1:0]              ex_pc_q, ex_a_q, ex_b_q, ex_rd2_q;

  assign ctl    = dec_ctl(if_inst[6:0]);
  assign rs[0]  = if_inst[15 +: PTR_W];
  assign rs[1]  = if_inst[20 +: PTR_W];
  assign use_rs = {ctl.use_rs2, ctl.use_rs1};
  assign imm_x  = XLEN'($signed(imm_gen(if_inst)));

  decode_regfile_p #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (rgf_we),
    .wa_i  (rgf_wa),
    .wd_i  (rgf_wd),
    .ra1_i (rs[0]),
    .ra2_i (rs[1]),
    .rd1_o (rf_rd[0]),
    .rd2_o (rf_rd[1])
  );

  // Scan oldest-to-youngest so the lowest-index matching source ends up selected.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      sel[k]  = FS_RF;
      fidx[k] = '0;
      if (rs[k] == '0) begin
        sel[k] = FS_ZERO;
      end else begin
        if (rgf_we && rgf_wa == rs[k]) sel[k] = FS_WB;
        for (int i = N_FWD-1; i >= 0; i--) begin
          if (fwd_we[i] && fwd_dst[i] == rs[k]) begin
            sel[k]  = FS_FWD;
            fidx[k] = FIDX_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    opnd = '0;
    for (int k = 0; k < 2; k++) begin
      case (sel[k])
        FS_ZERO: opnd[k] = '0;
        FS_FWD:  opnd[k] = fwd_dat[fidx[k]];
        FS_WB:   opnd[k] = rgf_wd;
        default: opnd[k] = rf_rd[k];
      endcase
    end
  end

  assign ex_is_load = (ex_inst_q[6:0] == OP_LOAD);
  assign ex_rd      = ex_inst_q[7 +: PTR_W];

  // A load completing this cycle is bypassed, so it releases its own interlock.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (use_rs[k] && rs[k] != '0) begin
        if (sb_q[rs[k]] && !(ld_done && ld_dst == rs[k])) hazard = 1'b1;
        if (ex_valid_q && ex_is_load && ex_rd == rs[k])   hazard = 1'b1;
      end
    end
  end

  assign can_load = !ex_valid_q || ex_ready;
  assign if_ready = flush || (can_load && !hazard);
  assign issue    = if_valid && if_ready && !flush;

  always_comb begin
    sb_d = sb_q;
    if (ld_done) sb_d[ld_dst] = 1'b0;
    if (ex_valid_q && ex_ready && ex_is_load && ex_rd != '0 && !flush) sb_d[ex_rd] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (if_valid && !if_ready && !flush && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_inst_q  <= BUBBLE;
      ex_pc_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_rd2_q   <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
      ex_inst_q  <= BUBBLE;
    end else if (issue) begin
      ex_valid_q <= 1'b1;
      ex_inst_q  <= if_inst;
      ex_pc_q    <= if_pc;
      ex_a_q     <= opnd[0];
      ex_b_q     <= ctl.b_is_rs2 ? opnd[1] : imm_x;
      ex_rd2_q   <= opnd[1];
    end else if (ex_valid_q && ex_ready) begin
      ex_valid_q <= 1'b0;
      ex_inst_q  <= BUBBLE;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_inst   = ex_inst_q;
  assign ex_pc     = ex_pc_q;
  assign ex_dat_a  = ex_a_q;
  assign ex_dat_b  = ex_b_q;
  assign ex_rd2    = ex_rd2_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage_sb.sv
// Randomised and directed bench for decode_stage_sb against a behavioural
// model of the decode/forward/interlock rules.
module tb_decode_stage_sb;
  localparam int XLEN = 32, NREGS = 32, N_FWD = 3, CNT_W = 2, PTR_W = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] BUB = 32'h0000_0013;

  logic clk = 1'b0, rst_n = 1'b0;
  logic if_valid, if_ready, ex_valid, ex_ready, flush, rgf_we, ld_done;
  logic [31:0] if_inst, ex_inst;
  logic [XLEN-1:0] if_pc, ex_pc, ex_dat_a, ex_dat_b, ex_rd2, rgf_wd;
  logic [N_FWD-1:0] fwd_we;
  logic [N_FWD-1:0][PTR_W-1:0] fwd_dst;
  logic [N_FWD-1:0][XLEN-1:0] fwd_dat;
  logic [PTR_W-1:0] rgf_wa, ld_dst;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  decode_stage_sb #(.XLEN(XLEN), .NREGS(NREGS), .N_FWD(N_FWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
    .if_pc(if_pc), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_dat_a(ex_dat_a), .ex_dat_b(ex_dat_b), .ex_rd2(ex_rd2), .flush(flush), .fwd_we(fwd_we),
    .fwd_dst(fwd_dst), .fwd_dat(fwd_dat), .rgf_we(rgf_we), .rgf_wa(rgf_wa), .rgf_wd(rgf_wd),
    .ld_done(ld_done), .ld_dst(ld_dst), .stall_cnt(stall_cnt));

  // Model state
  logic [31:0] m_regs [NREGS];
  bit          m_pend [NREGS];
  bit          m_v;
  logic [31:0] m_inst, m_pc, m_a, m_b, m_r2;
  int          m_cnt;
  int          n_cmp, n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    logic signed [31:0] s, s20, s19, s11;
    s = i; s20 = s >>> 20; s19 = s >>> 19; s11 = s >>> 11;
    case (i[6:0])
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h23: return (s20 & ~32'h1F) | {27'b0, i[11:7]};
      7'h6F: return (s11 & 32'hFFF0_0000) | (i & 32'h000F_F000) | {20'b0, i[20], 11'b0}
                    | {21'b0, i[30:21], 1'b0};
      7'h63: return (s19 & 32'hFFFF_F000) | {20'b0, i[7], 11'b0} | {21'b0, i[30:25], 5'b0}
                    | {27'b0, i[11:8], 1'b0};
      default: return s20;
    endcase
  endfunction

  function automatic bit m_use1(input logic [6:0] op);
    return op inside {7'h13, 7'h33, 7'h03, 7'h23, 7'h67, 7'h63};
  endfunction
  function automatic bit m_use2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic [31:0] m_opnd(input logic [4:0] r);
    if (r == 0) return 32'h0;
    for (int i = 0; i < N_FWD; i++)
      if (fwd_we[i] && fwd_dst[i] == r) return fwd_dat[i];
    if (rgf_we && rgf_wa == r) return rgf_wd;
    return m_regs[r];
  endfunction

  function automatic bit m_haz(input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (m_pend[r] && !(ld_done && ld_dst == r)) return 1'b1;
    if (m_v && m_inst[6:0] == 7'h03 && m_inst[11:7] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_v = 0; m_inst = BUB; m_pc = 0; m_a = 0; m_b = 0; m_r2 = 0; m_cnt = 0;
    for (int r = 0; r < NREGS; r++) begin m_pend[r] = 0; m_regs[r] = 0; end
  endtask

  task automatic set_idle();
    if_valid = 0; flush = 0; ex_ready = 1; fwd_we = '0; fwd_dst = '0; fwd_dat = '0;
    rgf_we = 0; rgf_wa = '0; rgf_wd = '0; ld_done = 0; ld_dst = '0;
  endtask

  // Called at a negedge with inputs set; compares, advances the model, returns at next negedge.
  task automatic cycle();
    bit haz, exp_rdy, iss;
    logic [31:0] i, na, nb, nr2;
    #1;
    i = if_inst;
    haz = (m_use1(i[6:0]) && m_haz(i[19:15])) || (m_use2(i[6:0]) && m_haz(i[24:20]));
    exp_rdy = flush || ((!m_v || ex_ready) && !haz);
    chk("if_ready", if_ready, exp_rdy);
    chk("ex_valid", ex_valid, m_v);
    chk("ex_inst", ex_inst, m_inst);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (m_v) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_dat_a", ex_dat_a, m_a);
      chk("ex_dat_b", ex_dat_b, m_b);
      chk("ex_rd2", ex_rd2, m_r2);
    end
    iss = if_valid && exp_rdy && !flush;
    na  = m_opnd(i[19:15]);
    nr2 = m_opnd(i[24:20]);
    nb  = (i[6:0] inside {7'h33, 7'h63}) ? nr2 : m_imm(i);
    if (ld_done) m_pend[ld_dst] = 0;
    if (m_v && ex_ready && !flush && m_inst[6:0] == 7'h03 && m_inst[11:7] != 0)
      m_pend[m_inst[11:7]] = 1;
    if (if_valid && !exp_rdy && !flush && m_cnt < CNT_MAX) m_cnt++;
    if (flush) begin m_v = 0; m_inst = BUB; end
    else if (iss) begin m_v = 1; m_inst = i; m_pc = if_pc; m_a = na; m_b = nb; m_r2 = nr2; end
    else if (m_v && ex_ready) begin m_v = 0; m_inst = BUB; end
    if (rgf_we) m_regs[rgf_wa] = rgf_wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic init_regs();
    set_idle();
    for (int r = 1; r < NREGS; r++) begin
      rgf_we = 1; rgf_wa = PTR_W'(r); rgf_wd = $urandom;
      cycle();
    end
    set_idle();
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_inst", ex_inst, BUB);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_dat_a", ex_dat_a, 0);
    chk("rst_ex_dat_b", ex_dat_b, 0);
    chk("rst_ex_rd2", ex_rd2, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic rand_inputs();
    logic [6:0] ops [9];
    logic [31:0] i;
    int pl[$];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    i = $urandom;
    i[6:0]   = ops[$urandom_range(8)];
    i[11:7]  = 5'($urandom_range(7));
    i[19:15] = 5'($urandom_range(7));
    i[24:20] = 5'($urandom_range(7));
    if_inst  = i;
    if_pc    = $urandom;
    if_valid = ($urandom_range(9) < 7);
    ex_ready = ($urandom_range(9) < 7);
    flush    = ($urandom_range(19) == 0);
    for (int k = 0; k < N_FWD; k++) begin
      fwd_we[k]  = ($urandom_range(3) == 0);
      fwd_dst[k] = PTR_W'($urandom_range(7));
      fwd_dat[k] = $urandom;
    end
    rgf_we = ($urandom_range(4) == 0);
    rgf_wa = PTR_W'($urandom_range(7));
    rgf_wd = $urandom;
    ld_done = 0;
    ld_dst  = PTR_W'($urandom_range(7));
    for (int r = 1; r < NREGS; r++) if (m_pend[r]) pl.push_back(r);
    if (pl.size() > 0 && $urandom_range(2) == 0) begin
      ld_done = 1;
      ld_dst  = PTR_W'(pl[$urandom_range(pl.size() - 1)]);
      rgf_we  = 1;
      rgf_wa  = ld_dst;
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    set_idle(); if_inst = BUB; if_pc = '0;
    model_reset();
    @(negedge clk);
    chk("init_ex_valid", ex_valid, 0);
    chk("init_ex_inst", ex_inst, BUB);
    chk("init_stall_cnt", stall_cnt, 0);
    rst_n = 1;
    init_regs();

    // ADDI x1,x0,5 then ADD x2,x1,x1 forwarded from execute
    if_valid = 1; if_inst = 32'h0050_0093; if_pc = 32'h100; cycle();
    chk("t1_addi_valid", ex_valid, 1);
    chk("t1_addi_b", ex_dat_b, 32'd5);
    if_inst = 32'h0010_8133; if_pc = 32'h104;
    fwd_we = 3'b001; fwd_dst[0] = 5'd1; fwd_dat[0] = 32'd5; cycle();
    chk("t1_add_a", ex_dat_a, 32'd5);
    chk("t1_add_b", ex_dat_b, 32'd5);
    chk("t1_add_pc", ex_pc, 32'h104);
    chk("t1_cnt", stall_cnt, 0);

    // LW x3 then dependent ADD x4,x3,x3; load returns 0xDEAD on the fifth try
    set_idle(); if_valid = 1; if_inst = 32'h0000_2183; cycle();
    if_inst = 32'h0031_8233;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t2_stall_rdy", if_ready, 0);
      cycle();
    end
    ld_done = 1; ld_dst = 5'd3; rgf_we = 1; rgf_wa = 5'd3; rgf_wd = 32'hDEAD;
    #1 chk("t2_release_rdy", if_ready, 1);
    cycle();
    chk("t2_a", ex_dat_a, 32'hDEAD);
    chk("t2_b", ex_dat_b, 32'hDEAD);
    chk("t2_cnt_sat", stall_cnt, 3);

    // LW x0 then ADD x5,x0,x0: no interlock
    set_idle(); if_valid = 1; if_inst = 32'h0000_2003; cycle();
    if_inst = 32'h0000_02B3;
    #1 chk("t3_rdy", if_ready, 1);
    cycle();
    chk("t3_a", ex_dat_a, 0);
    chk("t3_inst", ex_inst, 32'h0000_02B3);

    // Back-pressure holds ID/EX
    ex_ready = 0; if_inst = 32'h0050_0093;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t4_rdy", if_ready, 0);
      cycle();
      chk("t4_hold", ex_inst, 32'h0000_02B3);
    end
    ex_ready = 1; cycle();
    chk("t4_next", ex_inst, 32'h0050_0093);

    // Flush with LW x6 in ID/EX: no scoreboard set, dependent issues at once
    set_idle(); if_valid = 1; if_inst = 32'h0000_2303; cycle();
    flush = 1; if_inst = 32'h0050_0093; cycle();
    chk("t5_valid", ex_valid, 0);
    chk("t5_inst", ex_inst, BUB);
    flush = 0; if_inst = 32'h0063_03B3;
    #1 chk("t5_no_sb", if_ready, 1);
    cycle();
    chk("t5_issue", ex_valid, 1);

    // Saturating counter, then asynchronous reset mid-stall
    do_reset(); init_regs();
    if_valid = 1; if_inst = 32'h0000_2403; cycle();
    if_inst = 32'h0084_04B3;
    for (int k = 0; k < 6; k++) cycle();
    chk("t6_sat", stall_cnt, 3);
    do_reset(); init_regs();

    for (int it = 0; it < 4000; it++) begin
      if (it % 500 == 499) begin do_reset(); init_regs(); end
      rand_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage_sb.md
Name: decode_stage_sb

Overview:
- Next-generation decode stage: parametrised in data width, register count and number of forwarding sources.
- Adds a registered ID/EX pipeline boundary with valid/ready handshake on both sides.
- Adds a per-register load scoreboard that interlocks against variable-latency loads.
- Adds a saturating stall-cycle performance counter.
- Sits between fetch and execute; also hosts the architectural register file.

Parameters:
- XLEN, 32, datapath and PC width.
- NREGS, 32, architectural register count (power of 2); PTR_W = clog2(NREGS).
- N_FWD, 3, forwarding sources; index 0 = execute (highest priority), N_FWD-1 = oldest.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- if_valid  in  1  fetch instruction valid
- if_ready  out  1  decode accepts instruction this cycle
- if_inst  in  32  fetched instruction
- if_pc  in  XLEN  fetched PC
- ex_valid  out  1  ID/EX register holds valid instruction
- ex_ready  in  1  execute consumes ID/EX content this cycle
- ex_inst  out  32  registered instruction (BUBBLE when invalid)
- ex_pc  out  XLEN  registered PC
- ex_dat_a  out  XLEN  registered operand A (forwarded rs1)
- ex_dat_b  out  XLEN  registered operand B (forwarded rs2 for RR/BRANCH, else immediate)
- ex_rd2  out  XLEN  registered forwarded rs2 (store data)
- flush  in  1  branch flush from execute
- fwd_we  in  N_FWD  per-source write-enable
- fwd_dst  in  N_FWD*PTR_W  per-source destination
- fwd_dat  in  N_FWD*XLEN  per-source data
- rgf_we, rgf_wa, rgf_wd  in  1/PTR_W/XLEN  writeback port into register file
- ld_done  in  1  load result written back this cycle (coincides with rgf_we)
- ld_dst  in  PTR_W  destination of completing load
- stall_cnt  out  CNT_W  saturating interlock-stall cycle count

Interface rule (already decided): one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
Reset values:
- ex_valid=0; ex_inst=BUBBLE (32'h00000013); ex_pc, ex_dat_a, ex_dat_b, ex_rd2 = 0.
- Scoreboard all 0; stall_cnt=0.
- Reset mid-operation discards the ID/EX content and all pending bits immediately.

Decode:
- Immediate select per opcode: U for LUI/AUIPC, S for STORE, J for JAL, B for BRANCH, I otherwise.
- Sign-extension to XLEN.

Operand read enables:
- rs1 used for IMM/RR/LOAD/STORE/JALR/BRANCH.
- rs2 used for RR/STORE/BRANCH.

Forwarding (per operand):
- Lowest-index source wins when fwd_we[i]=1, fwd_dst[i]==rs and rs!=0.
- Next priority: writeback bypass (rgf_we & rgf_wa==rs & rs!=0).
- Otherwise: register file read.
- x0 always reads 0.

Scoreboard:
- One pending bit per register.
- Set when ex_valid & ex_ready & ID/EX holds a LOAD with rd!=0.
- Cleared when ld_done with matching ld_dst.
- Set and clear on the same register in the same cycle: set wins.

Hazard (combinational), for each used rs with rs!=0, any of:
- (a) scoreboard[rs]=1 and not (ld_done & ld_dst==rs).
- (b) ex_valid & ID/EX is LOAD & ID/EX rd==rs.

Handshake:
- can_load = ~ex_valid | ex_ready.
- if_ready = flush | (can_load & ~hazard).
- Issue = if_valid & if_ready & ~flush: the ID/EX register loads decoded content, ex_valid=1 next cycle.
- If ex_valid & ex_ready and no issue: ex_valid=0 and ex_inst=BUBBLE next cycle.
- If ~ex_ready & ex_valid: hold all outputs stable.

Flush (highest priority):
- Next cycle ex_valid=0 and ex_inst=BUBBLE.
- The presented fetch instruction is accepted and dropped.
- No scoreboard set occurs from the flushed ID/EX content.
- Loads already past ID/EX still clear normally.

stall_cnt:
- Increments when if_valid & ~if_ready & ~flush.
- Saturates at 2^CNT_W-1; never wraps.

Latency: 1 cycle fetch-to-ex_valid when no hazard.

Decomposition:
- Shared package utils_top gains OP_* opcodes (already present), BUBBLE, and a typedef for per-operand forward-select.
- Sub-module decode_regfile_p (parametrised XLEN/NREGS, two async read ports, one sync write port, x0 hardwired 0).
- Forwarding mux and scoreboard stay inline.

Test Plan:
1. ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back, fwd_dat[0]=5 with fwd_dst[0]=1 -> second instruction issues next cycle, ex_dat_a=ex_dat_b=5, stall_cnt=0.
2. LW x3 issues and moves to execute; next instruction ADD x4,x3,x3; ld_done after 4 cycles with rgf_wd=0xDEAD -> if_ready=0 for 4 cycles, issues with ex_dat_a=0xDEAD, stall_cnt=4.
3. LW x0 followed by ADD x5,x0,x0 -> no stall, ex_dat_a=0, scoreboard stays 0.
4. ex_ready=0 for 3 cycles with valid ID/EX -> ex_* outputs unchanged, if_ready=0; on ex_ready=1 the next instruction loads.
5. flush asserted with if_valid=1 and ID/EX holding LW x6 -> ex_valid=0, ex_inst=0x00000013, scoreboard[6]=0.
6. CNT_W=2, stall 6 cycles -> stall_cnt saturates at 3; rst_n pulsed low mid-stall -> all outputs return to reset values asynchronously.
